lelo_period_meter: RTL and testbench

- Reciprocal frequency meter for the LELO temperature oscillator. It is the on-chip consumer of the oscillator's digital output.
- It enables the oscillator, waits for it to settle, then counts fast system-clock cycles spanning N oscillator periods. The resulting temperature code is delivered over a valid/ready handshake.
- It sits between the analog macro (osc enable out, oscillator pulse in) and the digital readout logic.

---
 rtl/lelo_period_meter.sv | 164 ++++++++++++++++
 tb/tb_lelo_period_meter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/lelo_period_meter.sv
// rtl/lelo_period_meter.sv - reciprocal period meter for the LELO temperature oscillator
//
// Enables the oscillator, lets it settle, then counts clk cycles spanning
// N oscillator periods and offers the count over a valid/ready handshake.
//
// Ports:
//   clk          system clock, must exceed 2x the oscillator frequency
//   reset        synchronous, active-high
//   osc_in       asynchronous oscillator pulse from the analog macro
//   start        single-cycle request to begin a measurement (IDLE only)
//   n_periods    oscillator periods to span, latched on accepted start, 0 means 1
//   osc_en       oscillator enable to the analog macro
//   busy         high in every state except IDLE
//   result       measured clk cycles (all ones when overflow)
//   result_valid result available, held until result_ready
//   result_ready consumer accepts result
//   overflow     qualifies result: measurement saturated or timed out

module lelo_period_meter #(
    parameter int CNT_W      = 16,
    parameter int NPER_W     = 4,
    parameter int SETTLE_CYC = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              osc_in,
    input  logic              start,
    input  logic [NPER_W-1:0] n_periods,
    output logic              osc_en,
    output logic              busy,
    output logic [CNT_W-1:0]  result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              overflow
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        ARM     = 3'd2,
        MEASURE = 3'd3,
        HOLD    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    state_t state, next_state;

    logic              s1, s2, s3;
    logic [NPER_W-1:0] n_lat;
    logic [NPER_W-1:0] edge_cnt;
    logic [CNT_W-1:0]  timer;
    logic [CNT_W-1:0]  cnt;

    logic rise;
    logic settle_done;
    logic arm_timeout;
    logic meas_sat;
    logic last_edge;

    // Arming and stopping both use the same delayed strobe, so the
    // synchronizer latency cancels out of the measured count.
    assign rise        = s2 & ~s3;
    assign settle_done = (timer == SETTLE_LAST);
    assign arm_timeout = (timer == CNT_MAX);
    assign meas_sat    = (cnt == CNT_MAX);
    // edge_cnt never exceeds N-1, so the extra bit only guards the +1.
    assign last_edge   = rise &&
                         ((NPER_W+1)'(edge_cnt) + (NPER_W+1)'(1) == (NPER_W+1)'(n_lat));

    always_comb begin
        next_state   = state;
        osc_en       = 1'b0;
        busy         = 1'b1;
        result_valid = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) next_state = SETTLE;
            end
            SETTLE: begin
                osc_en = 1'b1;
                if (settle_done) next_state = ARM;
            end
            ARM: begin
                osc_en = 1'b1;
                if (rise)             next_state = MEASURE;
                else if (arm_timeout) next_state = HOLD;
            end
            MEASURE: begin
                osc_en = 1'b1;
                if (last_edge || meas_sat) next_state = HOLD;
            end
            HOLD: begin
                result_valid = 1'b1;
                if (result_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            n_lat    <= '0;
            edge_cnt <= '0;
            timer    <= '0;
            cnt      <= '0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            state <= next_state;
            s1    <= osc_in;
            s2    <= s1;
            s3    <= s2;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        n_lat <= (n_periods == '0) ? NPER_W'(1) : n_periods;
                        timer <= '0;
                    end
                end
                SETTLE: begin
                    // Timer is reused as the ARM timeout, so leave it cleared.
                    timer <= settle_done ? '0 : timer + 1'b1;
                end
                ARM: begin
                    if (rise) begin
                        cnt      <= '0;
                        edge_cnt <= '0;
                    end else if (arm_timeout) begin
                        result   <= CNT_MAX;
                        overflow <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                MEASURE: begin
                    // A completing edge at cnt == max would need max+1,
                    // which does not fit, so saturation wins there.
                    if (last_edge && !meas_sat) begin
                        result   <= cnt + 1'b1;
                        overflow <= 1'b0;
                    end else if (meas_sat) begin
                        result   <= CNT_MAX;
                        overflow <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (rise) edge_cnt <= edge_cnt + 1'b1;
                    end
                end
                HOLD: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lelo_period_meter.sv
// tb/tb_lelo_period_meter.sv - scoreboard bench for lelo_period_meter

module tb_lelo_period_meter;

    localparam int CNT_W      = 8;
    localparam int NPER_W     = 4;
    localparam int SETTLE_CYC = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              osc_in;
    logic              start;
    logic [NPER_W-1:0] n_periods;
    logic              osc_en;
    logic              busy;
    logic [CNT_W-1:0]  result;
    logic              result_valid;
    logic              result_ready;
    logic              overflow;

    lelo_period_meter #(
        .CNT_W      (CNT_W),
        .NPER_W     (NPER_W),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .osc_in       (osc_in),
        .start        (start),
        .n_periods    (n_periods),
        .osc_en       (osc_en),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CNT_W-1:0] r;
        logic             o;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_mis  = 0;
    int   hs_cnt = 0;
    int   osc_p  = 10;
    bit   osc_on = 1'b0;

    // Oscillator model: exactly osc_p clk cycles per period, changing off-edge.
    initial begin
        int ph;
        ph     = 0;
        osc_in = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (osc_on && osc_p > 1) begin
                ph     = (ph + 1) % osc_p;
                osc_in = (ph < osc_p / 2);
            end else begin
                ph     = 0;
                osc_in = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (result_valid === 1'b1 && result_ready === 1'b1) hs_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic launch(input int n, input int p, input int er, input bit eo);
        exp_t e;
        osc_p     = p;
        n_periods = NPER_W'(n);
        e.r       = CNT_W'(er);
        e.o       = eo;
        sb.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic collect(input string tag);
        int   k;
        exp_t e;
        k = 0;
        while (result_valid !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " valid"}, 32'(result_valid), 1);
        chk({tag, " sb_size"}, sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (result_valid === 1'b1) begin
                chk({tag, " result"}, 32'(result), 32'(e.r));
                chk({tag, " overflow"}, 32'(overflow), 32'(e.o));
            end
        end
    endtask

    task automatic ack();
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
    endtask

    initial begin
        int hs0;
        reset        = 1'b1;
        start        = 1'b0;
        result_ready = 1'b0;
        n_periods    = '0;
        tick(3);
        chk("rst busy", 32'(busy), 0);
        chk("rst osc_en", 32'(osc_en), 0);
        chk("rst valid", 32'(result_valid), 0);
        chk("rst result", 32'(result), 0);
        chk("rst overflow", 32'(overflow), 0);
        reset = 1'b0;
        tick(1);
        osc_on = 1'b1;

        launch(4, 10, 40, 1'b0);
        chk("t1 busy", 32'(busy), 1);
        chk("t1 osc_en", 32'(osc_en), 1);
        collect("t1");
        chk("t1 hold osc_en", 32'(osc_en), 0);
        chk("t1 hold busy", 32'(busy), 1);
        ack();
        chk("t1 idle busy", 32'(busy), 0);
        chk("t1 idle valid", 32'(result_valid), 0);
        chk("t1 idle osc_en", 32'(osc_en), 0);

        launch(0, 10, 10, 1'b0);
        collect("t2 n0");
        ack();
        launch(15, 7, 105, 1'b0);
        collect("t2 n15");
        ack();

        osc_on = 1'b0;
        launch(1, 10, 255, 1'b1);
        collect("t3 timeout");
        ack();
        osc_on = 1'b1;

        launch(4, 100, 255, 1'b1);
        collect("t4 sat");
        ack();

        hs0 = hs_cnt;
        launch(2, 10, 20, 1'b0);
        collect("t5");
        for (int i = 0; i < 20; i++) begin
            chk("t5 hold result", 32'(result), 20);
            chk("t5 hold overflow", 32'(overflow), 0);
            chk("t5 hold busy", 32'(busy), 1);
            chk("t5 hold valid", 32'(result_valid), 1);
            start = (i == 5);
            @(negedge clk);
        end
        start        = 1'b1;
        result_ready = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        result_ready = 1'b0;
        chk("t5 accept start ignored", 32'(busy), 0);
        chk("t5 one handshake", hs_cnt - hs0, 1);
        launch(3, 10, 30, 1'b0);
        chk("t5 restart busy", 32'(busy), 1);
        n_periods = 4'd9;
        collect("t5 rerun");
        ack();
        chk("t5 two handshakes", hs_cnt - hs0, 2);

        osc_p     = 10;
        n_periods = 4'd8;
        start     = 1'b1;
        tick(1);
        start = 1'b0;
        tick(30);
        chk("t6 mid busy", 32'(busy), 1);
        reset = 1'b1;
        tick(1);
        chk("t6 rst busy", 32'(busy), 0);
        chk("t6 rst osc_en", 32'(osc_en), 0);
        chk("t6 rst valid", 32'(result_valid), 0);
        chk("t6 rst result", 32'(result), 0);
        chk("t6 rst overflow", 32'(overflow), 0);
        reset = 1'b0;
        tick(1);
        launch(3, 10, 30, 1'b0);
        collect("t6 clean");
        ack();

        chk("sb empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
